// File: rtl/mem_request_unit.sv
// Data-memory request sequencer between the pipeline MEM stage and the RAM bus.
// It accepts one load, store, LL or SC request at a time and runs the RAM
// handshake until the RAM returns ACCESS or ERROR, or until a timeout expires.
// It also owns the LL/SC link register.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for dREN/dWEN; SC link check happens here
//   S_ACCESS | RAM strobes asserted, waiting for ACCESS/ERROR/timeout
//   S_DONE   | dhit asserted for one cycle, then back to S_IDLE
module mem_request_unit #(
    parameter int                WORD_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [WORD_W-1:0] BAD_DATA = 32'hBAD1BAD1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic              datomic,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dhit,
    output logic [WORD_W-1:0] dload,
    output logic              derr,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    input  logic              snoop_valid,
    input  logic [WORD_W-1:0] snoop_addr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;
    localparam logic [7:0] TO_CNT    = 8'(TIMEOUT);
    localparam logic [WORD_W-1:0] SC_OK = {{(WORD_W-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [WORD_W-1:0]     r_addr;
    logic                  r_is_wr;
    logic                  r_atomic;
    logic [7:0]            r_cnt;
    logic                  r_link_valid;
    logic [WORD_W-3:0]     r_link_word;

    logic                  w_req;
    logic                  w_sc_fail;
    logic                  w_snoop_hit;
    logic                  w_store_hits_link;
    logic                  w_snoop_byte_unused;

    // The link tracks whole words, so the byte offset of a snoop is irrelevant.
    assign w_snoop_byte_unused = ^snoop_addr[1:0];

    // Request decode and link comparisons used by the sequencer.
    assign w_req             = dREN | dWEN;
    assign w_sc_fail         = dWEN & datomic &
                               (~r_link_valid | (daddr[WORD_W-1:2] != r_link_word));
    assign w_snoop_hit       = snoop_valid & (snoop_addr[WORD_W-1:2] == r_link_word);
    assign w_store_hits_link = (r_addr[WORD_W-1:2] == r_link_word);

    // Request sequencer, RAM handshake, completion outputs and link register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_is_wr      <= 1'b0;
            r_atomic     <= 1'b0;
            r_cnt        <= '0;
            r_link_valid <= 1'b0;
            r_link_word  <= '0;
            dhit         <= 1'b0;
            derr         <= 1'b0;
            dload        <= '0;
            ramREN       <= 1'b0;
            ramWEN       <= 1'b0;
            ramaddr      <= '0;
            ramstore     <= '0;
        end else begin
            dhit <= 1'b0;

            // Snoop invalidation applies in every state; a completing LL below
            // overrides it because its assignment comes later.
            if (w_snoop_hit) begin
                r_link_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr   <= daddr;
                        r_is_wr  <= dWEN;
                        r_atomic <= datomic;
                        r_cnt    <= '0;
                        if (w_sc_fail) begin
                            // Failed SC never touches the RAM.
                            dload   <= '0;
                            derr    <= 1'b0;
                            dhit    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            ramREN   <= ~dWEN;
                            ramWEN   <= dWEN;
                            ramaddr  <= daddr;
                            ramstore <= dstore;
                            r_state  <= S_ACCESS;
                        end
                    end
                end

                S_ACCESS: begin
                    if (ramstate == RS_ACCESS) begin
                        ramREN  <= 1'b0;
                        ramWEN  <= 1'b0;
                        dhit    <= 1'b1;
                        derr    <= 1'b0;
                        r_state <= S_DONE;
                        if (!r_is_wr) begin
                            dload <= ramload;
                            if (r_atomic) begin
                                r_link_valid <= 1'b1;
                                r_link_word  <= r_addr[WORD_W-1:2];
                            end
                        end else if (r_atomic) begin
                            dload        <= SC_OK;
                            r_link_valid <= 1'b0;
                        end else if (w_store_hits_link) begin
                            r_link_valid <= 1'b0;
                        end
                    end else if ((ramstate == RS_ERROR) || (r_cnt == TO_CNT)) begin
                        ramREN  <= 1'b0;
                        ramWEN  <= 1'b0;
                        dhit    <= 1'b1;
                        derr    <= 1'b1;
                        dload   <= BAD_DATA;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_unit.sv
// Scoreboard bench for mem_request_unit: each test pushes the expected
// completion before driving a request, and run_req pops and compares it when
// dhit appears. A small RAM responder answers BUSY for a chosen number of
// strobe cycles and then a chosen final state.
module tb_mem_request_unit;

    localparam int          TIMEOUT  = 255;
    localparam logic [31:0] BAD_DATA = 32'hBAD1BAD1;
    localparam logic [1:0]  RS_FREE  = 2'd0;
    localparam logic [1:0]  RS_BUSY  = 2'd1;
    localparam logic [1:0]  RS_ACC   = 2'd2;
    localparam logic [1:0]  RS_ERR   = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        dREN = 1'b0, dWEN = 1'b0, datomic = 1'b0;
    logic [31:0] daddr = '0, dstore = '0;
    logic        dhit, derr, ramREN, ramWEN;
    logic [31:0] dload, ramaddr, ramstore;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = RS_FREE;
    logic        snoop_valid = 1'b0;
    logic [31:0] snoop_addr = '0;

    typedef struct {
        logic [31:0] dload;
        logic        derr;
        logic        chk_dload;
        int          lat;
        int          nstb;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   tb_cyc = 0;
    int   last_stamp = 0;

    mem_request_unit #(.WORD_W(32), .TIMEOUT(TIMEOUT), .BAD_DATA(BAD_DATA)) dut (
        .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .datomic(datomic),
        .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload), .derr(derr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) tb_cyc++;

    function automatic void push_exp(input logic [31:0] d, input logic e,
                                     input logic chk, input int lat, input int nstb);
        exp_t x;
        x.dload = d; x.derr = e; x.chk_dload = chk; x.lat = lat; x.nstb = nstb;
        sb.push_back(x);
    endfunction

    // Drive one request, act as the RAM, and score the completion against the queue.
    task automatic run_req(input logic wr, input logic at, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rl,
                           input int busy, input logic [1:0] fin);
        exp_t e;
        int   cyc = 0;
        int   ns = 0;
        bit   got = 0;
        bit   kind_bad = 0;
        bit   addr_bad = 0;
        logic [31:0] o_dload = '0;
        logic        o_derr = 1'b0;
        @(posedge CLK); #1;
        dWEN = wr; dREN = ~wr; datomic = at; daddr = addr; dstore = data;
        ramload = rl; ramstate = RS_FREE;
        while (!got && cyc < 400) begin
            @(negedge CLK);
            if (ramREN || ramWEN) begin
                ns++;
                if (ramWEN !== wr || ramREN !== ~wr) kind_bad = 1;
                if (ramaddr !== addr || (wr && ramstore !== data)) addr_bad = 1;
                ramstate = (ns > busy) ? fin : RS_BUSY;
            end else begin
                ramstate = RS_FREE;
            end
            if (dhit === 1'b1) begin
                got = 1; o_dload = dload; o_derr = derr; last_stamp = tb_cyc;
                dREN = 0; dWEN = 0; datomic = 0;
            end else begin
                cyc++;
            end
        end
        dREN = 0; dWEN = 0; datomic = 0; ramstate = RS_FREE;
        if (sb.size() == 0) begin
            n_err++; $display("FAIL scoreboard_empty addr=%h", addr);
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if (!got) begin n_err++; $display("FAIL dhit_timeout addr=%h no dhit in 400 cycles", addr); end
        n_vec++;
        if (cyc != e.lat) begin n_err++; $display("FAIL latency addr=%h got=%0d want=%0d", addr, cyc, e.lat); end
        n_vec++;
        if (ns != e.nstb) begin n_err++; $display("FAIL strobe_cycles addr=%h got=%0d want=%0d", addr, ns, e.nstb); end
        n_vec++;
        if (o_derr !== e.derr) begin n_err++; $display("FAIL derr addr=%h got=%b want=%b", addr, o_derr, e.derr); end
        if (e.chk_dload) begin
            n_vec++;
            if (o_dload !== e.dload) begin n_err++; $display("FAIL dload addr=%h got=%h want=%h", addr, o_dload, e.dload); end
        end
        if (ns > 0) begin
            n_vec++;
            if (kind_bad || addr_bad) begin
                n_err++; $display("FAIL ram_bus addr=%h kind_bad=%0d addr_bad=%0d want 0/0", addr, kind_bad, addr_bad);
            end
        end
    endtask

    task automatic snoop_now(input logic [31:0] a);
        @(posedge CLK); #1; snoop_valid = 1; snoop_addr = a;
        @(posedge CLK); #1; snoop_valid = 0;
    endtask

    // Snoop pulse during the first cycle after the next request's acceptance edge.
    task automatic snoop_in_cycle1(input logic [31:0] a);
        fork
            begin
                repeat (2) @(posedge CLK);
                #1; snoop_valid = 1; snoop_addr = a;
                @(posedge CLK); #1; snoop_valid = 0;
            end
        join_none
    endtask

    task automatic test_reset();
        nRST = 0;
        repeat (3) @(negedge CLK);
        n_vec++;
        if ({dhit, derr, ramREN, ramWEN} !== 4'b0000 || dload !== '0 || ramaddr !== '0 || ramstore !== '0) begin
            n_err++;
            $display("FAIL reset_values dhit=%b derr=%b ren=%b wen=%b dload=%h addr=%h store=%h want all 0",
                     dhit, derr, ramREN, ramWEN, dload, ramaddr, ramstore);
        end
        nRST = 1;
    endtask

    task automatic test_load();
        push_exp(32'hDEADBEEF, 0, 1, 2, 1);
        run_req(0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, RS_ACC);
    endtask

    task automatic test_store();
        push_exp('0, 0, 0, 5, 4);
        run_req(1, 0, 32'h200, 32'h12345678, 32'h0, 3, RS_ACC);
        @(negedge CLK);
        n_vec++;
        if (dhit !== 1'b0 || ramWEN !== 1'b0) begin
            n_err++; $display("FAIL store_after dhit=%b ramWEN=%b want 0/0", dhit, ramWEN);
        end
    endtask

    task automatic test_llsc();
        push_exp(32'hA5A50300, 0, 1, 2, 1);
        run_req(0, 1, 32'h300, 32'h0, 32'hA5A50300, 0, RS_ACC);
        push_exp(32'h1, 0, 1, 2, 1);
        run_req(1, 1, 32'h300, 32'h5, 32'h0, 0, RS_ACC);
        push_exp(32'h0, 0, 1, 1, 0);
        run_req(1, 1, 32'h300, 32'h5, 32'h0, 0, RS_ACC);
    endtask

    task automatic test_snoop();
        push_exp(32'h11110300, 0, 1, 2, 1);
        run_req(0, 1, 32'h300, 32'h0, 32'h11110300, 0, RS_ACC);
        snoop_now(32'h302);
        push_exp(32'h0, 0, 1, 1, 0);
        run_req(1, 1, 32'h300, 32'h7, 32'h0, 0, RS_ACC);
        push_exp(32'h22220300, 0, 1, 2, 1);
        run_req(0, 1, 32'h300, 32'h0, 32'h22220300, 0, RS_ACC);
        snoop_now(32'h304);
        push_exp(32'h1, 0, 1, 2, 1);
        run_req(1, 1, 32'h300, 32'h7, 32'h0, 0, RS_ACC);
    endtask

    task automatic test_store_link();
        push_exp(32'h600, 0, 1, 2, 1);
        run_req(0, 1, 32'h600, 32'h0, 32'h600, 0, RS_ACC);
        push_exp('0, 0, 0, 2, 1);
        run_req(1, 0, 32'h603, 32'h9, 32'h0, 0, RS_ACC);
        push_exp(32'h0, 0, 1, 1, 0);
        run_req(1, 1, 32'h600, 32'h9, 32'h0, 0, RS_ACC);
        push_exp(32'h700, 0, 1, 2, 1);
        run_req(0, 1, 32'h700, 32'h0, 32'h700, 0, RS_ACC);
        push_exp('0, 0, 0, 2, 1);
        run_req(1, 0, 32'h704, 32'h9, 32'h0, 0, RS_ACC);
        push_exp(32'h1, 0, 1, 2, 1);
        run_req(1, 1, 32'h700, 32'h9, 32'h0, 0, RS_ACC);
    endtask

    task automatic test_snoop_races();
        push_exp(32'h900, 0, 1, 2, 1);
        run_req(0, 1, 32'h900, 32'h0, 32'h900, 0, RS_ACC);
        snoop_in_cycle1(32'h900);
        push_exp(32'h1, 0, 1, 4, 3);
        run_req(1, 1, 32'h900, 32'h3, 32'h0, 2, RS_ACC);
        snoop_in_cycle1(32'hA00);
        push_exp(32'hA00, 0, 1, 2, 1);
        run_req(0, 1, 32'hA00, 32'h0, 32'hA00, 0, RS_ACC);
        push_exp(32'h1, 0, 1, 2, 1);
        run_req(1, 1, 32'hA00, 32'h4, 32'h0, 0, RS_ACC);
    endtask

    task automatic test_timeout();
        push_exp(BAD_DATA, 1, 1, TIMEOUT + 2, TIMEOUT + 1);
        run_req(0, 0, 32'h800, 32'h0, 32'h55555555, 100000, RS_ACC);
        push_exp(BAD_DATA, 1, 1, 4, 3);
        run_req(0, 0, 32'h804, 32'h0, 32'h66666666, 2, RS_ERR);
        push_exp(32'h77777777, 0, 1, 2, 1);
        run_req(0, 0, 32'h808, 32'h0, 32'h77777777, 0, RS_ACC);
    endtask

    task automatic test_reset_mid();
        push_exp(32'h400, 0, 1, 2, 1);
        run_req(0, 1, 32'h400, 32'h0, 32'h400, 0, RS_ACC);
        @(posedge CLK); #1;
        dWEN = 1; datomic = 0; daddr = 32'h500; dstore = 32'hCAFEF00D; ramstate = RS_BUSY;
        repeat (3) @(negedge CLK);
        n_vec++;
        if (ramWEN !== 1'b1) begin n_err++; $display("FAIL mid_access_wen got=%b want=1", ramWEN); end
        nRST = 0;
        @(negedge CLK);
        n_vec++;
        if (ramWEN !== 1'b0 || dhit !== 1'b0 || dload !== '0 || derr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort wen=%b dhit=%b dload=%h derr=%b want 0/0/0/0", ramWEN, dhit, dload, derr);
        end
        dWEN = 0; ramstate = RS_FREE;
        @(posedge CLK); #1; nRST = 1;
        push_exp(32'h0, 0, 1, 1, 0);
        run_req(1, 1, 32'h400, 32'h1, 32'h0, 0, RS_ACC);
        push_exp(32'h13572468, 0, 1, 2, 1);
        run_req(0, 0, 32'h104, 32'h0, 32'h13572468, 0, RS_ACC);
    endtask

    task automatic test_back_to_back();
        int s0, s1, s2;
        push_exp(32'hB0B0B0B0, 0, 1, 2, 1);
        run_req(0, 0, 32'hC00, 32'h0, 32'hB0B0B0B0, 0, RS_ACC);
        s0 = last_stamp;
        push_exp(32'hB1B1B1B1, 0, 1, 2, 1);
        run_req(0, 0, 32'hC04, 32'h0, 32'hB1B1B1B1, 0, RS_ACC);
        s1 = last_stamp;
        push_exp('0, 0, 0, 2, 1);
        run_req(1, 0, 32'hC08, 32'hABCD0123, 32'h0, 0, RS_ACC);
        s2 = last_stamp;
        n_vec++;
        if (s1 - s0 != 3 || s2 - s1 != 3) begin
            n_err++; $display("FAIL b2b_spacing got=%0d,%0d want=3,3", s1 - s0, s2 - s1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_store();
        test_llsc();
        test_snoop();
        test_store_link();
        test_snoop_races();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
- Data-memory request sequencer between the pipeline MEM stage and the RAM bus; the receiving end of the dREN/dWEN/LL/SC controls produced at decode.
- Captures one load, store, LL or SC request and drives the RAM handshake until ACCESS, ERROR or timeout.
- Returns dhit and dload to the pipeline.
- Owns the LL/SC link register, including SC success/fail resolution and link invalidation by local stores and external snoops.

Parameters:
- WORD_W, 32, data and address width.
- TIMEOUT, 255, max cycles in ACCESS before the unit forces an error completion (8-bit counter).
- BAD_DATA, 32'hBAD1BAD1, dload value returned on error or timeout.

Ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- dREN  in  1  load request; held until dhit
- dWEN  in  1  store request; held until dhit
- datomic  in  1  qualifies dREN as LL, dWEN as SC
- daddr  in  WORD_W  byte address
- dstore  in  WORD_W  store data
- dhit  out  1  one-cycle completion pulse
- dload  out  WORD_W  load data, or SC result
- derr  out  1  completion was ERROR or timeout; valid with dhit
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR
- snoop_valid  in  1  external write observed
- snoop_addr  in  WORD_W  address of the external write

Behaviour:
- Clock and reset: all state updates on the CLK rising edge. nRST low at an edge returns everything to reset values:
  - state IDLE
  - dhit=0, derr=0, dload=0
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0
  - link_valid=0, link_addr=0, timeout counter 0
- Reset mid-ACCESS abandons the transaction. The RAM strobes drop in the cycle after the reset edge.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If dWEN or dREN is high, latch daddr, dstore, type and datomic. dWEN has priority if both are high.
  - Exception, SC fail: datomic & dWEN & (!link_valid | link_addr[31:2] != daddr[31:2]). Go straight to DONE with dload=0, no RAM access.
  - Otherwise go to ACCESS and clear the counter.
- ACCESS:
  - ramREN/ramWEN/ramaddr/ramstore are driven from the latched copies only in this state; strobes are 0 in every other state.
  - ramstate==ACCESS: for a read, dload<=ramload. For an SC write, dload<=1 and link_valid<=0. Go to DONE with derr<=0.
  - ramstate==ERROR, or counter==TIMEOUT: dload<=BAD_DATA, derr<=1, go to DONE. The link register is unchanged.
  - Otherwise (FREE or BUSY), counter increments and the unit stays in ACCESS.
- DONE: dhit=1 for exactly one cycle, then unconditionally IDLE. A new request is accepted in the IDLE cycle that follows.
- Minimum latency: request visible in IDLE at cycle 0, strobes at cycle 1, ACCESS at cycle 1, dhit at cycle 2. Back-to-back requests are spaced 3 cycles apart.
- Link register:
  - A successful LL completion sets link_valid=1 and link_addr=latched addr.
  - A successful non-atomic store completion to the same word (addr[31:2]) clears link_valid.
  - snoop_valid with a matching word clears link_valid in any state.
  - If an LL completes in the same cycle as a matching snoop, the LL set wins.
  - A snoop matching while an SC is in ACCESS does not abort the SC. The SC already passed its check in IDLE.
- dload and derr hold their values until the next completion or reset.

Test Plan:
1. Reset then LW 0x100, ramstate ACCESS immediately with ramload 0xDEADBEEF -> ramREN high at cycle 1 only, dhit at cycle 2, dload=0xDEADBEEF, derr=0.
2. SW 0x200 data 0x12345678, ramstate BUSY for 3 cycles then ACCESS -> ramWEN high 4 cycles, ramaddr=0x200, ramstore=0x12345678, one dhit pulse, ramWEN=0 after.
3. LL 0x300 then SC 0x300 data 5 -> SC drives ramWEN, dload=1, link cleared; a second SC to 0x300 -> no ramWEN, dhit 1 cycle after request, dload=0.
4. LL 0x300, snoop_valid with snoop_addr 0x302, then SC 0x300 -> SC fails, dload=0, RAM untouched; repeat with snoop 0x304 -> SC succeeds.
5. LW with ramstate stuck BUSY -> dhit after TIMEOUT+1 cycles in ACCESS, dload=0xBAD1BAD1, derr=1; separately, ramstate ERROR -> same result one cycle after ERROR.
6. nRST low during ACCESS of SW -> ramWEN=0 the cycle after the edge, no dhit, link_valid=0; next LW completes normally.
